// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: word width, FSM state codes and the queue entry layout.
package fetch_sequencer_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fs_state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of {addr, instr} fetch entries; flush overrides push and pop.
module fetch_queue
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // NOTE: storage has no reset; only the occupancy state needs one, and an
  // unreset array maps onto plain registers or RAM without a clear path.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_DEPTH);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction pointer owner and fetch sequencer feeding decode through fetch_queue.
// Optional: define FETCH_TRACE_EN to print each captured fetch (simulation trace only).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter int                   QUEUE_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [WORD_SIZE-1:0] pointer,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] instr_addr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target,
  input  logic                 halt,
  input  logic                 resume,
  output logic                 halted
);

  localparam logic [WORD_SIZE-1:0] PTR_ONE = WORD_SIZE'(1);

  fs_state_e                   state, state_next;
  logic [WORD_SIZE-1:0]        pointer_next;
  logic                        pop, capture, q_pop;
  logic                        q_full, q_empty;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  fetch_entry_t                q_head, q_push_data;

  assign pop   = instr_valid && instr_ready;
  assign q_pop = pop && !redirect;
  assign q_push_data = '{addr: pointer, instr: mem_data};

  // Redirect and halt both cancel this edge's capture; a full queue still
  // captures when the head leaves on the same edge.
  always_comb begin
    state_next   = state;
    pointer_next = pointer;
    capture      = 1'b0;
    if (redirect) begin
      pointer_next = redirect_target;
    end else if (halt) begin
      state_next = FS_HALT;
    end else begin
      capture = (state == FS_RUN) && (!q_full || pop);
      if (capture) pointer_next = pointer + PTR_ONE;
      if (resume)  state_next   = FS_RUN;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FS_RUN;
      pointer <= RESET_VECTOR;
    end else begin
      state   <= state_next;
      pointer <= pointer_next;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .pop       (q_pop),
    .flush     (redirect),
    .push_data (q_push_data),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign instr_valid = !q_empty;
  assign instr       = q_head.instr;
  assign instr_addr  = q_head.addr;
  assign halted      = (state == FS_HALT);

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && capture) $display("ip = %d, instr = %x", pointer, mem_data);
  end
`else
`endif

endmodule
